button_input: RTL and testbench

Input-side front end for the LED display path. It samples active-low push buttons, then synchronizes and debounces each one. Accepted presses are encoded into the 3-bit LED selection code and the 10-bit state word that the LED output stage consumes. It is the producer of `led_sel` and `state`, and sits between the board buttons and the LED output stage.

---
 rtl/button_input.sv | 139 +++++++++++++
 tb/tb_button_input.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_input.sv
// Button front end: synchronizes and debounces 8 select buttons and 1 mode button,
// then encodes accepted presses into led_sel / state. Optional auto-repeat: BUTTON_AUTOREPEAT_EN.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_CYCLES   = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] btn_n,
  input  logic       btn_mode_n,
  output logic [2:0] led_sel,
  output logic [9:0] state,
  output logic       press_pulse
);

  localparam int NIN = 9;  // index 8 is the mode button
  localparam int DW  = $clog2(DEBOUNCE_CYCLES);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
    $error("button_input: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
  end

  logic [NIN-1:0]         sync1_q, sync2_q, pressed;
  logic [NIN-1:0]         stable_q, stable_d, prev_q, rise;
  logic [NIN-1:0][DW-1:0] cnt_q, cnt_d;
  logic [2:0]             led_sel_q, led_sel_d, win, ev_sel;
  logic [8:0]             count_q, count_d;
  logic                   mode_q, mode_d, pulse_q, pulse_d;
  logic                   sel_rise, rep_fire;

  // Synchronizer flops idle at 1 so a reset never looks like a press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {btn_mode_n, btn_n};
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NIN; i++) begin
      cnt_d[i] = cnt_q[i] + 1'b1;
      if (pressed[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d[i] = pressed[i];
        cnt_d[i]    = '0;
      end
    end
  end

  // NOTE: the counters are a packed register bank, not a RAM, so a full async reset is cheap and safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q    <= cnt_d;
    end
  end

  assign rise     = stable_q & ~prev_q;
  assign sel_rise = |rise[7:0];

  // Lowest-indexed rising select button wins; the rest are dropped.
  always_comb begin
    win = '0;
    for (int i = 7; i >= 0; i--) begin
      if (rise[i]) win = 3'(i);
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);

  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  // Counts from the last event while the selected button stays accepted; a new rise restarts it.
  always_comb begin
    rep_fire  = 1'b0;
    rep_cnt_d = rep_cnt_q + 1'b1;
    if (sel_rise || !stable_q[led_sel_q]) begin
      rep_cnt_d = '0;
    end else if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
      rep_fire  = 1'b1;
      rep_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_q <= '0;
    else        rep_cnt_q <= rep_cnt_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_comb begin
    led_sel_d = led_sel_q;
    count_d   = count_q;
    mode_d    = mode_q ^ rise[8];
    pulse_d   = 1'b0;
    ev_sel    = sel_rise ? win : led_sel_q;
    if (sel_rise || rep_fire) begin
      led_sel_d = ev_sel;
      count_d   = count_q + 1'b1;
      pulse_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_sel_q <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      led_sel_q <= led_sel_d;
      count_q   <= count_d;
      mode_q    <= mode_d;
      pulse_q   <= pulse_d;
    end
  end

  assign led_sel     = led_sel_q;
  assign state       = {mode_q, count_q};
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_input.sv
// Scoreboard bench for button_input: press stimulus predicts pulses from hold durations,
// a negedge monitor matches each press_pulse (cycle, led_sel, state) against the queue.
module tb_button_input;

  localparam int D   = 4;
  localparam int R   = 10;
  localparam int GAP = D + 8;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic [7:0] btn_n      = '1;
  logic       btn_mode_n = 1'b1;
  logic [2:0] led_sel;
  logic [9:0] state;
  logic       press_pulse;

  button_input #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_n      (btn_n),
    .btn_mode_n (btn_mode_n),
    .led_sel    (led_sel),
    .state      (state),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [2:0]  sel;
    logic [9:0]  st;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_total = 0;
  int          n_pass  = 0;

  // Reference model state: what led_sel / state should read once the bench is idle.
  logic [8:0]  m_cnt  = '0;
  logic        m_mode = 1'b0;
  logic [2:0]  m_sel  = '0;

  logic [7:0]  r_mask;
  logic        r_mode;
  int          r_len;
  int          n_wrap;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] mask);
    for (int i = 0; i < 8; i++) if (mask[i]) return 3'(i);
    return 3'd0;
  endfunction

  // A button held low for len sampled cycles is accepted iff len >= D; its event
  // appears D+2 edges after the first sampling edge, i.e. edge c+D+3.
  task automatic push_events(input int unsigned c, input logic [7:0] mask, input logic m,
                             input int len);
    exp_t e;
    if (len < D) return;
    if (m) m_mode = ~m_mode;
    if (mask == 8'h00) return;
    m_sel  = lowest(mask);
    m_cnt  = m_cnt + 9'd1;
    e.cyc  = c + D + 3;
    e.sel  = m_sel;
    e.st   = {m_mode, m_cnt};
    exp_q.push_back(e);
`ifdef BUTTON_AUTOREPEAT_EN
    for (int k = 1; k * R <= len - 1; k++) begin
      m_cnt = m_cnt + 9'd1;
      e.cyc = c + D + 3 + k * R;
      e.st  = {m_mode, m_cnt};
      exp_q.push_back(e);
    end
`endif
  endtask

  task automatic press(input logic [7:0] mask, input logic m, input int len);
    push_events(cyc, mask, m, len);
    btn_n      = ~mask;
    btn_mode_n = ~m;
    step(len);
    btn_n      = '1;
    btn_mode_n = 1'b1;
    step(GAP);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_led_sel"}, led_sel, m_sel);
    check({tag, "_state"}, state, {m_mode, m_cnt});
  endtask

  // Monitor: flags overdue expectations, then matches each observed strobe.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_total++;
      $display("FAIL pulse_missing: no pulse by cycle %0d, expected at cycle %0d led_sel=%0d state=0x%0h",
               cyc, mon_e.cyc, mon_e.sel, mon_e.st);
    end
    if (rst_n && press_pulse) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d led_sel=%0d state=0x%0h, expected none",
                 cyc, led_sel, state);
      end else begin
        mon_e = exp_q.pop_front();
        check("pulse_cycle", cyc, mon_e.cyc);
        check("pulse_led_sel", led_sel, mon_e.sel);
        check("pulse_state", state, mon_e.st);
      end
    end
  end

  initial begin
    step(2);
    check("reset_led_sel", led_sel, 0);
    check("reset_state", state, 0);
    check("reset_pulse", press_pulse, 0);
    rst_n = 1'b1;
    step(2);

    // Glitch: 3 low, 2 high, 3 low never reaches D stable cycles.
    btn_n[5] = 1'b0; step(3);
    btn_n[5] = 1'b1; step(2);
    btn_n[5] = 1'b0; step(3);
    btn_n[5] = 1'b1; step(GAP);
    check("glitch_led_sel", led_sel, 0);
    check("glitch_state", state, 0);

    press(8'h08, 1'b0, 20);
    check("basic_led_sel", led_sel, 3);
    check("basic_state", state, 10'h001);

    press(8'h44, 1'b1, D + 2);
    check("simul_led_sel", led_sel, 2);
    check("simul_mode", state[9], 1);

    // Back-to-back rises on different buttons in consecutive cycles.
    push_events(cyc, 8'h40, 1'b0, D + 2);
    btn_n[6] = 1'b0; step(1);
    push_events(cyc, 8'h02, 1'b0, D + 2);
    btn_n[1] = 1'b0; step(D + 1);
    btn_n[6] = 1'b1; step(1);
    btn_n[1] = 1'b1; step(GAP);
    check_idle("b2b");

    press(8'h00, 1'b1, D + 1);
    check("mode_toggle_a", state[9], 0);
    press(8'h00, 1'b1, D + 1);
    check("mode_toggle_b", state[9], 1);

    press(8'h10, 1'b0, 40);
    check_idle("hold40");

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(3))
        0, 1:    r_mask = 8'(1 << $urandom_range(7));
        2:       r_mask = 8'($urandom_range(255));
        default: r_mask = 8'h00;
      endcase
      r_mode = ($urandom_range(3) == 0);
      r_len  = ($urandom_range(4) == 0) ? int'($urandom_range(3 * R, R)) : int'($urandom_range(D + 3, 1));
      press(r_mask, r_mode, r_len);
      check_idle("random");
    end

    // Drive the counter to 511 -> 0.
    n_wrap = (m_cnt == 9'd0) ? 512 : 512 - int'(m_cnt);
    for (int i = 0; i < n_wrap; i++) press(8'(1 << $urandom_range(7)), 1'b0, D);
    check("wrap_count", state[8:0], 0);
    check_idle("wrap");

    // Reset mid-debounce with the button still held through release.
    btn_n[1] = 1'b0;
    step(3);
    rst_n = 1'b0;
    #1;
    check("rst_led_sel", led_sel, 0);
    check("rst_state", state, 0);
    check("rst_pulse", press_pulse, 0);
    step(2);
    m_cnt  = '0;
    m_mode = 1'b0;
    m_sel  = '0;
    rst_n  = 1'b1;
    push_events(cyc, 8'h02, 1'b0, 8);
    step(8);
    btn_n[1] = 1'b1;
    step(GAP);
    check_idle("post_rst");

    step(GAP);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
